// File: rtl/exec_hazard_ctrl.sv
// Execute-stage hazard controller for the LC-3 pipeline: operand forwarding, load-use and
// branch bubbles, memory freeze. Define EXEC_BYPASS_EN to enable forwarding (default: stall-only).
module exec_hazard_ctrl #(
    parameter int BR_WAIT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        ir_valid,
    input  logic        mem_stall,
    output logic        enable_execute,
    output logic        enable_decode,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2
);

    typedef struct packed {
        logic       valid;
        logic       writes;
        logic       is_load;
        logic [2:0] dr;
    } slot_t;

    typedef enum logic {
        S_RUN,
        S_BR_WAIT
    } state_t;

    localparam logic [2:0] BR_WAIT_CNT = 3'(BR_WAIT);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    slot_t      slot_e, slot_m, dec;

    logic [3:0] opcode;
    logic       use1, use2;
    logic [2:0] src1, src2;
    logic       is_branch;
    logic       hazard;
    logic       alu_1, alu_2, mem_1, mem_2;

    // IR[4:3] are immediate bits that no hazard rule inspects.
    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[4:3];

    function automatic logic feeds(input slot_t s, input logic [2:0] r);
        return s.valid & s.writes & (s.dr == r);
    endfunction

    assign opcode    = IR[15:12];
    assign is_branch = (opcode == 4'b0000) || (opcode == 4'b1100);

    // Source-operand decode; nothing is "used" when IR does not hold a real instruction.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        src1 = IR[8:6];
        src2 = IR[2:0];
        case (opcode)
            4'b0001, 4'b0101: begin
                use1 = 1'b1;
                use2 = ~IR[5];
            end
            4'b1001, 4'b0110, 4'b1100: use1 = 1'b1;
            4'b0111: begin
                use1 = 1'b1;
                use2 = 1'b1;
                src2 = IR[11:9];
            end
            4'b0011, 4'b1011: begin
                use2 = 1'b1;
                src2 = IR[11:9];
            end
            default: ;
        endcase
        use1 = use1 & ir_valid;
        use2 = use2 & ir_valid;
    end

    always_comb begin
        dec.valid   = 1'b1;
        dec.writes  = (IR[13:12] == 2'b01) || (IR[13:12] == 2'b10);
        dec.is_load = (opcode == 4'b0010) || (opcode == 4'b0110) || (opcode == 4'b1010);
        dec.dr      = IR[11:9];
    end

`ifdef EXEC_BYPASS_EN
    // A load in E has no data yet, so it can only be forwarded once it reaches M.
    always_comb begin
        alu_1  = use1 & feeds(slot_e, src1) & ~slot_e.is_load;
        alu_2  = use2 & feeds(slot_e, src2) & ~slot_e.is_load;
        mem_1  = use1 & ~alu_1 & feeds(slot_m, src1);
        mem_2  = use2 & ~alu_2 & feeds(slot_m, src2);
        hazard = (use1 & feeds(slot_e, src1) & slot_e.is_load)
               | (use2 & feeds(slot_e, src2) & slot_e.is_load);
    end
`else
    always_comb begin
        alu_1  = 1'b0;
        alu_2  = 1'b0;
        mem_1  = 1'b0;
        mem_2  = 1'b0;
        hazard = (use1 & (feeds(slot_e, src1) | feeds(slot_m, src1)))
               | (use2 & (feeds(slot_e, src2) | feeds(slot_m, src2)));
    end
`endif

    assign bypass_alu_1 = alu_1 & ~reset;
    assign bypass_alu_2 = alu_2 & ~reset;
    assign bypass_mem_1 = mem_1 & ~reset;
    assign bypass_mem_2 = mem_2 & ~reset;

    // mem_stall and reset override the FSM; state and count hold by default.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        enable_execute = 1'b0;
        enable_decode  = 1'b0;
        if (!reset && !mem_stall) begin
            case (state)
                S_RUN: begin
                    enable_execute = ir_valid & ~hazard;
                    enable_decode  = ~hazard;
                    if (enable_execute && is_branch) begin
                        state_nxt = S_BR_WAIT;
                        cnt_nxt   = BR_WAIT_CNT;
                    end
                end
                S_BR_WAIT: begin
                    cnt_nxt = cnt - 3'd1;
                    if (cnt == 3'd1) state_nxt = S_RUN;
                end
                default: state_nxt = S_RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_RUN;
            cnt    <= 3'd0;
            slot_e <= '0;
            slot_m <= '0;
        end else if (!mem_stall) begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            slot_m <= slot_e;
            slot_e <= enable_execute ? dec : slot_t'('0);
        end
    end

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Self-checking bench for exec_hazard_ctrl: directed vector table plus randomized run
// against an instruction-level pipeline model. Honors EXEC_BYPASS_EN like the design.
module tb_exec_hazard_ctrl;

    localparam int BR_WAIT = 3;
`ifdef EXEC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ir = 16'h0000;
    logic        ir_valid = 1'b0;
    logic        mem_stall = 1'b0;
    logic        enable_execute, enable_decode;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [5:0]  dut_out;

    int n_compared = 0;
    int n_mismatched = 0;

    exec_hazard_ctrl #(.BR_WAIT(BR_WAIT)) dut (
        .clock          (clock),
        .reset          (reset),
        .IR             (ir),
        .ir_valid       (ir_valid),
        .mem_stall      (mem_stall),
        .enable_execute (enable_execute),
        .enable_decode  (enable_decode),
        .bypass_alu_1   (bypass_alu_1),
        .bypass_alu_2   (bypass_alu_2),
        .bypass_mem_1   (bypass_mem_1),
        .bypass_mem_2   (bypass_mem_2)
    );

    always #5 clock = ~clock;

    assign dut_out = {enable_execute, enable_decode, bypass_alu_1, bypass_alu_2,
                      bypass_mem_1, bypass_mem_2};

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: ee,ed,ba1,ba2,bm1,bm2 got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        logic [15:0] ir;
        bit          iv;
        bit          ms;
        logic [5:0]  exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input logic [15:0] i, input bit iv, input bit ms,
                       input logic [5:0] e);
        vec_t v;
        v.rst = r; v.ir = i; v.iv = iv; v.ms = ms; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic fill_table();
        // ALU forwarding of both sources
        add(1, 16'h1283, 1, 0, 6'b000000);
        add(0, 16'h1283, 1, 0, 6'b110000);
`ifdef EXEC_BYPASS_EN
        add(0, 16'h1841, 1, 0, 6'b111100);
`else
        add(0, 16'h1841, 1, 0, 6'b000000);
        add(0, 16'h1841, 1, 0, 6'b000000);
        add(0, 16'h1841, 1, 0, 6'b110000);
`endif
        // memory-stage forwarding
        add(1, 16'h0000, 0, 0, 6'b000000);
        add(0, 16'h1283, 1, 0, 6'b110000);
        add(0, 16'h1705, 1, 0, 6'b110000);
`ifdef EXEC_BYPASS_EN
        add(0, 16'h1841, 1, 0, 6'b110011);
`else
        add(0, 16'h1841, 1, 0, 6'b000000);
        add(0, 16'h1841, 1, 0, 6'b110000);
`endif
        // load-use
        add(1, 16'h0000, 0, 0, 6'b000000);
        add(0, 16'h6280, 1, 0, 6'b110000);
        add(0, 16'h1661, 1, 0, 6'b000000);
`ifdef EXEC_BYPASS_EN
        add(0, 16'h1661, 1, 0, 6'b110010);
`else
        add(0, 16'h1661, 1, 0, 6'b000000);
        add(0, 16'h1661, 1, 0, 6'b110000);
`endif
        // immediate form has no second source
        add(1, 16'h0000, 0, 0, 6'b000000);
        add(0, 16'h1705, 1, 0, 6'b110000);
        add(0, 16'h12A3, 1, 0, 6'b110000);
        // branch bubbles
        add(1, 16'h0000, 0, 0, 6'b000000);
        add(0, 16'h0E02, 1, 0, 6'b110000);
        add(0, 16'h1283, 1, 0, 6'b000000);
        add(0, 16'h1283, 1, 0, 6'b000000);
        add(0, 16'h1283, 1, 0, 6'b000000);
        add(0, 16'h1283, 1, 0, 6'b110000);
        // reset during the second branch bubble
        add(1, 16'h0000, 0, 0, 6'b000000);
        add(0, 16'h0E02, 1, 0, 6'b110000);
        add(0, 16'h1283, 1, 0, 6'b000000);
        add(1, 16'h1283, 1, 0, 6'b000000);
        add(0, 16'h1283, 1, 0, 6'b110000);
        // memory stall freezes the pipe with a dependent ADD pending
        add(1, 16'h0000, 0, 0, 6'b000000);
        add(0, 16'h1283, 1, 0, 6'b110000);
`ifdef EXEC_BYPASS_EN
        add(0, 16'h1841, 1, 1, 6'b001100);
        add(0, 16'h1841, 1, 1, 6'b001100);
        add(0, 16'h1841, 1, 0, 6'b111100);
`else
        add(0, 16'h1841, 1, 1, 6'b000000);
        add(0, 16'h1841, 1, 1, 6'b000000);
        add(0, 16'h1841, 1, 0, 6'b000000);
        add(0, 16'h1841, 1, 0, 6'b000000);
        add(0, 16'h1841, 1, 0, 6'b110000);
`endif
        // invalid IR: bubble, decode free, bypass forced off
        add(1, 16'h0000, 0, 0, 6'b000000);
        add(0, 16'h1283, 1, 0, 6'b110000);
        add(0, 16'h1841, 0, 0, 6'b010000);
`ifdef EXEC_BYPASS_EN
        add(0, 16'h1841, 1, 0, 6'b110011);
`else
        add(0, 16'h1841, 1, 0, 6'b000000);
        add(0, 16'h1841, 1, 0, 6'b110000);
`endif
    endtask

    // ---------------- instruction-level reference model ----------------
    typedef struct {
        bit          v;
        logic [15:0] ir;
    } inflight_t;

    inflight_t pipe[$];   // pipe[0]: result in aluout, pipe[1]: in memory stage
    int        br_left;

    function automatic bit writes_reg(input logic [15:0] w);
        return (w[13:12] == 2'b01) || (w[13:12] == 2'b10);
    endfunction

    function automatic bit is_ld(input logic [15:0] w);
        return (w[15:12] == 4'd2) || (w[15:12] == 4'd6) || (w[15:12] == 4'd10);
    endfunction

    function automatic bit feeds(input inflight_t p, input logic [2:0] r);
        return p.v && writes_reg(p.ir) && (p.ir[11:9] == r);
    endfunction

    task automatic model_reset();
        inflight_t nop;
        nop.v = 1'b0; nop.ir = 16'h0000;
        pipe.delete();
        pipe.push_back(nop);
        pipe.push_back(nop);
        br_left = 0;
    endtask

    task automatic model_eval(input bit r, input logic [15:0] w, input bit iv, input bit ms,
                              output logic [5:0] exp);
        bit         use_s[2];
        logic [2:0] src[2];
        bit         alu[2], mem[2];
        bit         hazard, ee, ed;
        int         op;
        exp = '0;
        if (r) return;
        op = int'(w[15:12]);
        use_s[0] = 0; use_s[1] = 0;
        src[0] = w[8:6];
        src[1] = w[2:0];
        if (op == 1 || op == 5) begin
            use_s[0] = 1; use_s[1] = !w[5];
        end else if (op == 9 || op == 6 || op == 12) begin
            use_s[0] = 1;
        end else if (op == 7) begin
            use_s[0] = 1; use_s[1] = 1; src[1] = w[11:9];
        end else if (op == 3 || op == 11) begin
            use_s[1] = 1; src[1] = w[11:9];
        end
        hazard = 0;
        for (int k = 0; k < 2; k++) begin
            alu[k] = 0; mem[k] = 0;
            if (iv && use_s[k]) begin
                if (BYP) begin
                    alu[k] = feeds(pipe[0], src[k]) && !is_ld(pipe[0].ir);
                    mem[k] = !alu[k] && feeds(pipe[1], src[k]);
                    if (feeds(pipe[0], src[k]) && is_ld(pipe[0].ir)) hazard = 1;
                end else if (feeds(pipe[0], src[k]) || feeds(pipe[1], src[k])) begin
                    hazard = 1;
                end
            end
        end
        if (ms || br_left > 0) begin
            ee = 0; ed = 0;
        end else begin
            ee = iv && !hazard;
            ed = !hazard;
        end
        exp = {ee, ed, alu[0], alu[1], mem[0], mem[1]};
    endtask

    task automatic model_clock(input bit r, input logic [15:0] w, input bit ms, input bit ee);
        inflight_t nxt;
        if (r) begin
            model_reset();
        end else if (!ms) begin
            nxt.v  = ee;
            nxt.ir = ee ? w : 16'h0000;
            pipe.push_front(nxt);
            void'(pipe.pop_back());
            if (br_left > 0) br_left--;
            else if (ee && (w[15:12] == 4'd0 || w[15:12] == 4'd12)) br_left = BR_WAIT;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] exp;
        bit         r, iv, ms;
        logic [15:0] w;

        fill_table();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            reset = vecs[i].rst; ir = vecs[i].ir;
            ir_valid = vecs[i].iv; mem_stall = vecs[i].ms;
            #2;
            check($sformatf("vec%0d", i), dut_out, vecs[i].exp);
            @(posedge clock);
        end

        model_reset();
        for (int c = 0; c < 800; c++) begin
            r  = (c == 0) || ($urandom_range(0, 39) == 0);
            iv = ($urandom_range(0, 7) != 0);
            ms = ($urandom_range(0, 5) == 0);
            w  = 16'($urandom);
            w[11:9] = 3'($urandom_range(0, 3));
            w[8:6]  = 3'($urandom_range(0, 3));
            w[2:0]  = 3'($urandom_range(0, 3));
            @(negedge clock);
            reset = r; ir = w; ir_valid = iv; mem_stall = ms;
            model_eval(r, w, iv, ms, exp);
            #2;
            check($sformatf("rand%0d", c), dut_out, exp);
            @(posedge clock);
            model_clock(r, w, ms, exp[5]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
